// File: rtl/ddf_1p_2f_switch_pkg.sv
// ----------------------------------------------------------------------------
// ddf_1p_2f_switch_pkg
// Shared definitions for the 2-flux dynamic-dataflow SWITCH actor:
//   - state encoding of the control FSM
//   - bit positions of the fields inside a control (NDA) token
// ----------------------------------------------------------------------------
package ddf_1p_2f_switch_pkg;

   // IDLE waits for a control token; ROUTE forwards its data tokens
   typedef enum logic {
      IDLE  = 1'b0,
      ROUTE = 1'b1
   } state_t;

   // Control token layout: [0] = destination flux, [W-1:1] = token count - 1
   localparam int SEL_BIT = 0;
   localparam int CNT_LSB = 1;

endpackage : ddf_1p_2f_switch_pkg

// File: rtl/ddf_1p_2f_switch.sv
// ----------------------------------------------------------------------------
// ddf_1p_2f_switch
// Dynamic-dataflow SWITCH actor. Pops a control token from the NDA FIFO, then
// forwards cnt+1 data tokens from the data FIFO to the flux selected by the
// token (flux 0 or flux 1). Data path is combinational (zero latency).
//
// Ports:
//   ck         in   clock, rising edge
//   rst        in   synchronous active-high reset
//   nda_empty  in   control FIFO empty
//   nda_read   out  control FIFO pop strobe
//   nda_data   in   control token {cnt, sel} (FWFT)
//   in_empty   in   data FIFO empty
//   in_read    out  data FIFO pop strobe
//   in_data    in   data token (FWFT)
//   out0_full  in   flux-0 downstream full
//   out0_wr    out  flux-0 write strobe
//   out0_data  out  flux-0 data (= in_data)
//   out1_full  in   flux-1 downstream full
//   out1_wr    out  flux-1 write strobe
//   out1_data  out  flux-1 data (= in_data)
// ----------------------------------------------------------------------------
module ddf_1p_2f_switch
   import ddf_1p_2f_switch_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int WIDTH_NDA = 8
) (
   input  logic                 ck,
   input  logic                 rst,
   input  logic                 nda_empty,
   output logic                 nda_read,
   input  logic [WIDTH_NDA-1:0] nda_data,
   input  logic                 in_empty,
   output logic                 in_read,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 out0_full,
   output logic                 out0_wr,
   output logic [WIDTH-1:0]     out0_data,
   input  logic                 out1_full,
   output logic                 out1_wr,
   output logic [WIDTH-1:0]     out1_data
);

   localparam int CNT_W = WIDTH_NDA - 1;
   localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};

   state_t           state_r;
   logic             sel_r;
   logic [CNT_W-1:0] rem_r;

   logic             sel_full_s;
   logic             xfer_s;
   logic             nda_pop_s;

   // Handshake decode: strobes are combinational and forced low during reset
   always_comb begin
      sel_full_s = 1'b0;
      xfer_s     = 1'b0;
      nda_pop_s  = 1'b0;
      if (sel_r) begin
         sel_full_s = out1_full;
      end else begin
         sel_full_s = out0_full;
      end
      if (rst) begin
         xfer_s    = 1'b0;
         nda_pop_s = 1'b0;
      end else if (state_r == ROUTE) begin
         // full on the non-selected flux is deliberately ignored
         xfer_s    = !in_empty && !sel_full_s;
         nda_pop_s = 1'b0;
      end else begin
         xfer_s    = 1'b0;
         nda_pop_s = !nda_empty;
      end
   end

   assign nda_read  = nda_pop_s;
   assign in_read   = xfer_s;
   assign out0_wr   = xfer_s && !sel_r;
   assign out1_wr   = xfer_s &&  sel_r;
   assign out0_data = in_data;
   assign out1_data = in_data;

   // Control FSM plus remaining-token counter; exit at rem_r==0 so no underflow
   always_ff @(posedge ck) begin
      if (rst) begin
         state_r <= IDLE;
         sel_r   <= 1'b0;
         rem_r   <= REM_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (nda_pop_s) begin
                  sel_r   <= nda_data[SEL_BIT];
                  rem_r   <= nda_data[WIDTH_NDA-1:CNT_LSB];
                  state_r <= ROUTE;
               end
            end
            ROUTE: begin
               if (xfer_s) begin
                  if (rem_r == REM_ZERO) begin
                     state_r <= IDLE;
                  end else begin
                     rem_r <= rem_r - REM_ONE;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule : ddf_1p_2f_switch

// File: tb/tb_ddf_1p_2f_switch.sv
// ----------------------------------------------------------------------------
// tb_ddf_1p_2f_switch
// Directed, table-driven bench for the 2-flux SWITCH actor. Each table row is
// one clock cycle: inputs are driven just after the rising edge, strobes and
// data outputs are compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_ddf_1p_2f_switch;

   logic       ck;
   logic       rst;
   logic       nda_empty;
   logic       nda_read;
   logic [7:0] nda_data;
   logic       in_empty;
   logic       in_read;
   logic [7:0] in_data;
   logic       out0_full;
   logic       out0_wr;
   logic [7:0] out0_data;
   logic       out1_full;
   logic       out1_wr;
   logic [7:0] out1_data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic       ne;
      logic [7:0] nd;
      logic       ie;
      logic [7:0] id;
      logic       f0;
      logic       f1;
      logic [3:0] exp;   // {nda_read, in_read, out0_wr, out1_wr}
   } vec_t;

   vec_t vecs[$];

   ddf_1p_2f_switch #(.WIDTH(8), .WIDTH_NDA(8)) dut (
      .ck        (ck),
      .rst       (rst),
      .nda_empty (nda_empty),
      .nda_read  (nda_read),
      .nda_data  (nda_data),
      .in_empty  (in_empty),
      .in_read   (in_read),
      .in_data   (in_data),
      .out0_full (out0_full),
      .out0_wr   (out0_wr),
      .out0_data (out0_data),
      .out1_full (out1_full),
      .out1_wr   (out1_wr),
      .out1_data (out1_data)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   function automatic vec_t mk(input logic r, input logic ne, input logic [7:0] nd,
                               input logic ie, input logic [7:0] id,
                               input logic f0, input logic f1, input logic [3:0] exp);
      vec_t v;
      v.rst = r; v.ne = ne; v.nd = nd; v.ie = ie; v.id = id;
      v.f0 = f0; v.f1 = f1; v.exp = exp;
      return v;
   endfunction

   // Drive one cycle's inputs after the edge, compare on the falling edge
   task automatic run_cycle(input vec_t v, input string name, input int idx);
      logic [3:0] got;
      @(posedge ck);
      #1;
      rst = v.rst; nda_empty = v.ne; nda_data = v.nd;
      in_empty = v.ie; in_data = v.id; out0_full = v.f0; out1_full = v.f1;
      @(negedge ck);
      got = {nda_read, in_read, out0_wr, out1_wr};
      checks++;
      if (got !== v.exp) begin
         errors++;
         $display("FAIL %s[%0d] strobes {nda_read,in_read,out0_wr,out1_wr}: got %b want %b",
                  name, idx, got, v.exp);
      end
      checks++;
      if (out0_data !== v.id || out1_data !== v.id) begin
         errors++;
         $display("FAIL %s[%0d] data: got out0=%h out1=%h want %h",
                  name, idx, out0_data, out1_data, v.id);
      end
   endtask

   initial begin
      rst = 1'b1; nda_empty = 1'b1; nda_data = 8'h00; in_empty = 1'b1;
      in_data = 8'h00; out0_full = 1'b0; out1_full = 1'b0;

      //             rst   ne    nd     ie    id     f0    f1    exp
      // reset, then token 0x00 -> one word 0xA5 to flux 0
      vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 4'b0000));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 4'b1000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 4'b0110));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 8'hA6, 1'b0, 1'b0, 4'b0000));
      // token 0x07 -> 0x10..0x13 to flux 1, out1_full stall 2 cycles after 2nd
      vecs.push_back(mk(1'b0, 1'b0, 8'h07, 1'b0, 8'h10, 1'b0, 1'b0, 4'b1000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h07, 1'b0, 8'h10, 1'b0, 1'b0, 4'b0101));
      vecs.push_back(mk(1'b0, 1'b1, 8'h07, 1'b0, 8'h11, 1'b1, 1'b0, 4'b0101));
      vecs.push_back(mk(1'b0, 1'b1, 8'h07, 1'b0, 8'h12, 1'b1, 1'b1, 4'b0000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h07, 1'b0, 8'h12, 1'b0, 1'b1, 4'b0000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h07, 1'b0, 8'h12, 1'b1, 1'b0, 4'b0101));
      vecs.push_back(mk(1'b0, 1'b1, 8'h07, 1'b0, 8'h13, 1'b0, 1'b0, 4'b0101));
      // idle with data present but no control token
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h55, 1'b0, 1'b0, 4'b0000));
      // token 0x04 -> 3 words to flux 0, data FIFO empty 3 cycles mid-run
      vecs.push_back(mk(1'b0, 1'b0, 8'h04, 1'b0, 8'h20, 1'b0, 1'b0, 4'b1000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b0, 8'h20, 1'b0, 1'b0, 4'b0110));
      vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b1, 8'h21, 1'b0, 1'b0, 4'b0000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b1, 8'h21, 1'b0, 1'b0, 4'b0000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b1, 8'h21, 1'b1, 1'b0, 4'b0000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b0, 8'h21, 1'b0, 1'b1, 4'b0110));
      vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b0, 8'h22, 1'b0, 1'b0, 4'b0110));
      vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b0, 8'h23, 1'b0, 1'b0, 4'b0000));
      // back-to-back tokens 0x01 then 0x00
      vecs.push_back(mk(1'b0, 1'b0, 8'h01, 1'b0, 8'h30, 1'b0, 1'b0, 4'b1000));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h30, 1'b0, 1'b0, 4'b0101));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h31, 1'b0, 1'b0, 4'b1000));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h31, 1'b0, 1'b0, 4'b0110));
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 8'h32, 1'b0, 1'b0, 4'b0000));

      for (int i = 0; i < vecs.size(); i++) begin
         run_cycle(vecs[i], "table", i);
      end

      // Reset in the middle of token 0xFF (sel 1, 128 words) after 5 transfers
      run_cycle(mk(1'b0, 1'b0, 8'hFF, 1'b0, 8'h40, 1'b0, 1'b0, 4'b1000), "rst_mid", 0);
      for (int i = 0; i < 5; i++) begin
         run_cycle(mk(1'b0, 1'b1, 8'hFF, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b0, 4'b0101),
                   "rst_mid_xfer", i);
      end
      // reset cycle: data and a control token are available, yet no strobes
      run_cycle(mk(1'b1, 1'b0, 8'h02, 1'b0, 8'h45, 1'b0, 1'b0, 4'b0000), "rst_cycle", 0);
      // stale count must not resume
      for (int i = 0; i < 3; i++) begin
         run_cycle(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h45, 1'b0, 1'b0, 4'b0000),
                   "post_rst_idle", i);
      end
      // new token 0x00 after reset -> single word to flux 0
      run_cycle(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h46, 1'b0, 1'b0, 4'b1000), "post_rst_tok", 0);
      run_cycle(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h46, 1'b0, 1'b0, 4'b0110), "post_rst_tok", 1);
      run_cycle(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h47, 1'b0, 1'b0, 4'b0000), "post_rst_tok", 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_ddf_1p_2f_switch

// File: doc/ddf_1p_2f_switch.md
Name: ddf_1p_2f_switch

Overview:
- Dynamic-dataflow SWITCH actor; the producer-side dual of the 2-flux PICK actor.
- Consumes control tokens from an NDA FIFO and data tokens from a single data FIFO.
- Routes each data token to one of two output fluxes, each feeding a downstream multi-flux FIFO write port (per-flux wr/full).
- Sits between a standard first-word-fall-through input FIFO pair and a 2-flux FIFO.

Parameters:
- WIDTH, 8, data token width.
- WIDTH_NDA, 8, control token width; must be >= 2.

Ports:
- ck  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- nda_empty  in  1  control FIFO empty.
- nda_read  out  1  control FIFO pop strobe.
- nda_data  in  WIDTH_NDA  control token (FWFT, valid while !nda_empty).
- in_empty  in  1  data FIFO empty.
- in_read  out  1  data FIFO pop strobe.
- in_data  in  WIDTH  data token (FWFT).
- out0_full  in  1  flux-0 downstream full.
- out0_wr  out  1  flux-0 write strobe.
- out0_data  out  WIDTH  flux-0 data.
- out1_full  in  1  flux-1 downstream full.
- out1_wr  out  1  flux-1 write strobe.
- out1_data  out  WIDTH  flux-1 data.

Behaviour:
- Control token fields:
  - sel = nda_data[0], the destination flux.
  - cnt = nda_data[WIDTH_NDA-1:1].
  - Number of data tokens routed = cnt+1, so range 1..2^(WIDTH_NDA-1).
- State registers:
  - state {IDLE, ROUTE}.
  - sel_q (1 bit).
  - rem_q (WIDTH_NDA-1 bits), the remaining tokens minus 1.
- Strobes are combinational from state, registers and the empty/full inputs; they are active within the same cycle, and a pop/push takes effect at the rising edge.
- IDLE:
  - nda_read = !nda_empty.
  - When nda_read is asserted: sel_q <= sel, rem_q <= cnt, state <= ROUTE.
  - in_read, out0_wr and out1_wr are 0.
- ROUTE:
  - xfer = !in_empty && !outSel_full, where outSel_full is out0_full if sel_q==0, else out1_full.
  - in_read = xfer.
  - outK_wr = xfer && (sel_q==K).
  - Non-selected flux wr is always 0.
  - Full on the non-selected flux is ignored.
  - On xfer with rem_q!=0: rem_q <= rem_q-1.
  - On xfer with rem_q==0: state <= IDLE.
  - nda_read = 0 throughout ROUTE.
- Data path: out0_data = out1_data = in_data. No registering, so zero latency from FIFO head to output.
- Throughput:
  - 1 data token per cycle while in ROUTE and unblocked.
  - Exactly one bubble cycle, the IDLE control-pop cycle, per control token.
- Stalls:
  - in_empty or the selected full holds all state; no strobes are asserted.
  - Simultaneous in_empty and full also means no strobe.
- Counter wrap: rem_q never underflows, because the exit happens at 0.
- Reset, including mid-ROUTE:
  - Next state is IDLE; sel_q=0, rem_q=0.
  - A partially routed control token's remaining count is discarded.
  - During any cycle with rst=1, all strobes (nda_read, in_read, out0_wr, out1_wr) are forced to 0.
  - After reset, outputs are: strobes 0; data outputs follow in_data.
- Invariants:
  - out0_wr and out1_wr are never both 1.
  - in_read == out0_wr | out1_wr.
  - nda_read and in_read are never both 1.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, ROUTE=1'b1) and the field positions SEL_BIT=0 and CNT_LSB=1.
- No sub-module; a single FSM plus counter.
- The matching top-level test wrapper instantiates two standard FIFOs (data and NDA) in front, and the 2-flux FIFO behind, this actor.

Test Plan:
- Reset then NDA token 0x00 (sel 0, cnt 0) with data 0xA5 present:
  - Cycle 1: nda_read=1.
  - Cycle 2: out0_wr=1, out0_data=0xA5, in_read=1, out1_wr=0.
  - Then back to IDLE.
- NDA token 0x07 (sel 1, cnt 3) with data 0x10..0x13 queued: out1_wr high for 4 consecutive cycles carrying 0x10, 0x11, 0x12, 0x13 in order, with no out0_wr.
- Stall in the above run by asserting out1_full for 2 cycles after the second token:
  - in_read and out1_wr drop for exactly those cycles.
  - No token is lost or duplicated; out0_full toggling has no effect.
- Data FIFO empty for 3 cycles mid-run of token 0x04 (sel 0, cnt 2): strobes stay low, then the remaining tokens go out to flux 0; the total on flux 0 is 3.
- Back-to-back NDA tokens 0x01 then 0x00:
  - One token goes to flux 1, then one to flux 0.
  - Exactly one IDLE cycle separates them.
  - Never both wr strobes asserted.
- Assert rst for one cycle in the middle of token 0xFF (sel 1, cnt 127), after 5 transfers:
  - No strobes during the reset cycle.
  - After reset the actor waits for a new NDA token; the stale remaining count is not resumed.
